// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: 4-digit 7-segment scan sequencer with shadowed patterns and frame-atomic commit.
// Define SEG_SCAN_DIM_EN to add the duty[3:0] input for PWM dimming.
module seg_scan_ctrl #(
    parameter int CLK_DIV   = 50000,
    parameter int BLANK_CYC = 500,
    parameter int CNT_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [6:0] wr_data,
    input  logic       commit,
    input  logic [3:0] digit_en,
`ifdef SEG_SCAN_DIM_EN
    input  logic [3:0] duty,
`endif
    output logic       busy,
    output logic       frame_tick,
    output logic [1:0] sel,
    output logic [3:0] an,
    output logic [6:0] seg
);
    typedef enum logic {SHOW, BLANK} state_t;
    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC > 0 ? BLANK_CYC - 1 : 0);
    state_t state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [1:0] sel_nx;
    logic [6:0] shadow [4];
    logic [6:0] active [4];
    logic pending, advance, boundary, lit, dim_ok;
`ifdef SEG_SCAN_DIM_EN
    logic [3:0] pwm_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pwm_cnt <= '0;
        else pwm_cnt <= pwm_cnt + 4'd1;
    assign dim_ok = pwm_cnt < duty;
`else
    assign dim_ok = 1'b1;
`endif
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt + 1'b1;
        advance  = 1'b0;
        if (state == SHOW && cnt == SHOW_LAST) begin
            cnt_nx = '0;
            if (BLANK_CYC > 0) state_nx = BLANK;
            else advance = 1'b1;
        end else if (state == BLANK && cnt == BLANK_LAST) begin
            cnt_nx   = '0;
            state_nx = SHOW;
            advance  = 1'b1;
        end
        sel_nx   = advance ? sel + 2'd1 : sel;
        boundary = advance && sel == 2'd3;
        lit      = state == SHOW && digit_en[sel] && dim_ok;
    end
    assign busy = pending;
    // A commit landing on the boundary itself is held over to the next frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= SHOW;
            cnt        <= '0;
            sel        <= '0;
            pending    <= 1'b0;
            frame_tick <= 1'b0;
            an         <= 4'hF;
            seg        <= 7'h7F;
            for (int i = 0; i < 4; i++) begin
                shadow[i] <= 7'h7F;
                active[i] <= 7'h7F;
            end
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            sel        <= sel_nx;
            frame_tick <= boundary;
            pending    <= (boundary && pending) ? commit : (pending | commit);
            an         <= lit ? ~(4'b0001 << sel) : 4'hF;
            seg        <= lit ? active[sel] : 7'h7F;
            if (wr_en) shadow[wr_addr] <= wr_data;
            if (boundary && pending)
                for (int i = 0; i < 4; i++) active[i] <= shadow[i];
        end
    end
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed bench for seg_scan_ctrl with CLK_DIV=4, BLANK_CYC=2 (24-cycle frame).
module tb_seg_scan_ctrl;
    logic clk = 1'b0, rst_n = 1'b0, wr_en = 1'b0, commit = 1'b0;
    logic [1:0] wr_addr = '0;
    logic [6:0] wr_data = '0;
    logic [3:0] digit_en = 4'hF;
    logic busy, frame_tick;
    logic [1:0] sel;
    logic [3:0] an;
    logic [6:0] seg;
    int t = 0, n_tests = 0, n_fail = 0;
    logic [6:0] disp [4] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
    logic [3:0] en_exp = 4'hF;
    logic busy_exp = 1'b0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.CLK_DIV(4), .BLANK_CYC(2), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .commit(commit), .digit_en(digit_en), .busy(busy), .frame_tick(frame_tick),
        .sel(sel), .an(an), .seg(seg)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s t=%0d observed=%h expected=%h", tag, t, obs, exp);
        end
    endtask

    // Edge t: outputs reflect the state before edge t; digit slot = 6 cycles (4 lit + 2 blank).
    task automatic step();
        int d, p;
        logic lit;
        logic [3:0] an_e;
        logic [6:0] seg_e;
        @(negedge clk);
        t++;
        d = ((t - 1) / 6) % 4;
        p = (t - 1) % 6;
        lit = p < 4 && en_exp[d];
        an_e = lit ? ~(4'b0001 << d) : 4'hF;
        seg_e = lit ? disp[d] : 7'h7F;
        chk("an", {4'h0, an}, {4'h0, an_e});
        chk("seg", {1'b0, seg}, {1'b0, seg_e});
        chk("sel", {6'h0, sel}, 8'((t / 6) % 4));
        chk("frame_tick", {7'h0, frame_tick}, {7'h0, t % 24 == 0});
        chk("busy", {7'h0, busy}, {7'h0, busy_exp});
    endtask

    task automatic run_to(input int n);
        while (t < n) step();
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_an"}, {4'h0, an}, 8'h0F);
        chk({tag, "_seg"}, {1'b0, seg}, 8'h7F);
        chk({tag, "_sel"}, {6'h0, sel}, 8'h00);
        chk({tag, "_busy"}, {7'h0, busy}, 8'h00);
        chk({tag, "_tick"}, {7'h0, frame_tick}, 8'h00);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;
        run_to(24);
        // load shadows, commit mid-frame, publish at edge 48
        wr_en = 1'b1; wr_addr = 2'd0; wr_data = 7'h40; step();
        wr_addr = 2'd1; wr_data = 7'h79; step();
        wr_addr = 2'd2; wr_data = 7'h24; step();
        wr_addr = 2'd3; wr_data = 7'h30; step();
        wr_en = 1'b0; commit = 1'b1; busy_exp = 1'b1; step();
        commit = 1'b0;
        run_to(47);
        busy_exp = 1'b0;
        disp = '{7'h40, 7'h79, 7'h24, 7'h30};
        step();
        // uncommitted write stays invisible
        run_to(49);
        wr_en = 1'b1; wr_addr = 2'd2; wr_data = 7'h12; step();
        wr_en = 1'b0;
        run_to(143);
        // commit + write on the boundary cycle: applied one frame later, including the write
        commit = 1'b1; wr_en = 1'b1; wr_addr = 2'd1; wr_data = 7'h00; busy_exp = 1'b1; step();
        commit = 1'b0; wr_en = 1'b0;
        run_to(167);
        busy_exp = 1'b0;
        disp = '{7'h40, 7'h00, 7'h12, 7'h30};
        step();
        // write during a boundary copy: copy takes the old shadow value
        run_to(175);
        commit = 1'b1; busy_exp = 1'b1; step();
        commit = 1'b0;
        run_to(191);
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = 7'h55; busy_exp = 1'b0; step();
        wr_en = 1'b0;
        run_to(216);
        // digit mask
        digit_en = 4'b0101; en_exp = 4'b0101;
        run_to(245);
        commit = 1'b1; busy_exp = 1'b1; step();
        commit = 1'b0;
        run_to(253);
        // asynchronous reset mid-digit 2
        #2 rst_n = 1'b0;
        #1 check_reset("async_reset");
        @(negedge clk);
        rst_n = 1'b1; t = 0; busy_exp = 1'b0;
        digit_en = 4'hF; en_exp = 4'hF;
        disp = '{7'h7F, 7'h7F, 7'h7F, 7'h7F};
        run_to(3);
        // shadow was cleared by reset, so a commit publishes blanks
        commit = 1'b1; busy_exp = 1'b1; step();
        commit = 1'b0;
        run_to(23);
        busy_exp = 1'b0;
        run_to(48);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
